// File: rtl/pipeline_fetch_queue.sv
// pipeline_fetch_queue: IF stage with PC generation, kernel-bit
// protection, a DEPTH-entry prefetch queue and the IF/ID register.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   PCSrc         0 seq, 1 branch, 2 J, 3 JR, 4 ILLOP, 5 XADR (6/7 = seq)
//   ALUOut0       branch taken, qualifies PCSrc=1
//   ConBA         branch target
//   JT            26-bit jump field
//   DatabusA      JR target
//   Stall         ID hold request, freezes IFID/ifid_valid
//   imem_addr     word address into instruction memory (PC[IMEM_AW+1:2])
//   imem_rdata    instruction at imem_addr, same cycle
//   IFID          {PC+4, Ins} of the instruction in ID
//   ifid_valid    IFID holds a real instruction
//   PC31          kernel-mode bit of the fetch PC
//   q_count       prefetch queue occupancy
module pipeline_fetch_queue #(
    parameter int             XLEN     = 32,
    parameter int             DEPTH    = 4,
    parameter int             IMEM_AW  = 7,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter logic [XLEN-1:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [XLEN-1:0] XADR_PC  = 32'h8000_0008
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 PCSrc,
    input  logic                       ALUOut0,
    input  logic [XLEN-1:0]            ConBA,
    input  logic [25:0]                JT,
    input  logic [XLEN-1:0]            DatabusA,
    input  logic                       Stall,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic [2*XLEN-1:0]          IFID,
    output logic                       ifid_valid,
    output logic                       PC31,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_seq;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_tgt;
    logic [2*XLEN-1:0] word;

    logic [2*XLEN-1:0] qmem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic redirect;
    logic empty;
    logic full;
    logic pop;
    logic bypass;
    logic fetch;
    logic push;

    assign imem_addr = pc[IMEM_AW+1:2];
    assign PC31      = pc[XLEN-1];
    assign q_count   = count;

    // Sequential increment keeps the kernel bit: a user PC
    // wraps to zero instead of carrying into kernel space.
    assign pc_seq   = {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
    assign pc_plus4 = pc + XLEN'(4);
    assign word     = {pc_plus4, imem_rdata};

    always_comb begin
        redirect = 1'b0;
        pc_tgt   = pc_seq;
        case (PCSrc)
            3'd1: begin
                if (ALUOut0) begin
                    redirect = 1'b1;
                    pc_tgt   = ConBA;
                end
            end
            3'd2: begin
                redirect = 1'b1;
                pc_tgt   = {pc[XLEN-1:28], JT, 2'b00};
            end
            3'd3: begin
                // JR may only stay in or leave kernel mode,
                // never enter it from user mode.
                redirect = 1'b1;
                pc_tgt   = {pc[XLEN-1] & DatabusA[XLEN-1],
                            DatabusA[XLEN-2:0]};
            end
            3'd4: begin
                redirect = 1'b1;
                pc_tgt   = ILLOP_PC;
            end
            3'd5: begin
                redirect = 1'b1;
                pc_tgt   = XADR_PC;
            end
            default: begin
                redirect = 1'b0;
                pc_tgt   = pc_seq;
            end
        endcase
    end

    assign empty  = (count == CW'(0));
    assign full   = (count == CW'(DEPTH));
    assign pop    = !Stall && !empty;
    assign bypass = !Stall && empty;
    assign fetch  = !full || pop || bypass;
    // Bypassed words skip the queue entirely.
    assign push   = fetch && !bypass;

    always_ff @(posedge clk) begin
        if (!reset && !redirect && push) begin
            qmem[tail] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            IFID       <= '0;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= pc_tgt;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            IFID       <= '0;
            ifid_valid <= 1'b0;
        end else begin
            if (fetch) begin
                pc <= pc_seq;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head       <= head + PW'(1);
                IFID       <= qmem[head];
                ifid_valid <= 1'b1;
            end else if (bypass) begin
                IFID       <= word;
                ifid_valid <= 1'b1;
            end
            // A pop always comes with a push, so only a
            // stalled push changes occupancy.
            if (push && !pop) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Testbench for pipeline_fetch_queue: vector table for PC/queue state
// plus an in-order scoreboard of expected IFID words.
module tb_pipeline_fetch_queue;

    logic        clk;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        ALUOut0;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] DatabusA;
    logic        Stall;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] IFID;
    logic        ifid_valid;
    logic        PC31;
    logic [2:0]  q_count;

    pipeline_fetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .ALUOut0    (ALUOut0),
        .ConBA      (ConBA),
        .JT         (JT),
        .DatabusA   (DatabusA),
        .Stall      (Stall),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .IFID       (IFID),
        .ifid_valid (ifid_valid),
        .PC31       (PC31),
        .q_count    (q_count)
    );

    // imem[i] = 0x1000_0000 + i
    assign imem_rdata = 32'h1000_0000 + {25'd0, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  src;
        logic        alu;
        logic [31:0] conba;
        logic [25:0] jt;
        logic [31:0] dba;
        logic [2:0]  cnt;
        logic [6:0]  addr;
        logic        pc31;
        logic        ld;
        logic [31:0] spc;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    logic [63:0] last_exp;
    logic        last_vld;
    int          checks;
    int          errors;

    function automatic logic [63:0] word_at(input logic [31:0] pc);
        return {pc + 32'd4, 32'h1000_0000 + {25'd0, pc[8:2]}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_stream(input logic [31:0] start);
        logic [31:0] p;
        sb.delete();
        p = start;
        for (int k = 0; k < 64; k++) begin
            sb.push_back(word_at(p));
            p = p + 32'd4;
        end
    endtask

    task automatic add(input logic rst, input logic stall,
                       input logic [2:0] src, input logic alu,
                       input logic [31:0] conba,
                       input logic [25:0] jt,
                       input logic [31:0] dba,
                       input logic [2:0] cnt,
                       input logic [6:0] addr,
                       input logic pc31, input logic ld,
                       input logic [31:0] spc);
        vec_t v;
        v.rst = rst;     v.stall = stall; v.src = src;
        v.alu = alu;     v.conba = conba; v.jt = jt;
        v.dba = dba;     v.cnt = cnt;     v.addr = addr;
        v.pc31 = pc31;   v.ld = ld;       v.spc = spc;
        vecs.push_back(v);
    endtask

    // One clock edge; IFID is compared against the scoreboard
    // according to what the applied inputs imply.
    task automatic tick();
        logic        rn;
        logic        rd;
        logic        st;
        logic [63:0] e;
        rn = reset;
        st = Stall;
        rd = (PCSrc == 3'd1 && ALUOut0) ||
             (PCSrc >= 3'd2 && PCSrc <= 3'd5);
        @(posedge clk);
        #1;
        if (rn || rd) begin
            chk("ifid_clear", IFID, 64'd0);
            chk("valid_clear", {63'd0, ifid_valid}, 64'd0);
            last_exp = 64'd0;
            last_vld = 1'b0;
        end else if (!st) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got %h expected none", IFID);
            end else begin
                e = sb.pop_front();
                chk("ifid_word", IFID, e);
                chk("ifid_valid", {63'd0, ifid_valid}, 64'd1);
                last_exp = e;
                last_vld = 1'b1;
            end
        end else begin
            chk("ifid_hold", IFID, last_exp);
            chk("valid_hold", {63'd0, ifid_valid}, {63'd0, last_vld});
        end
    endtask

    initial begin
        logic [2:0] mc;
        checks   = 0;
        errors   = 0;
        last_exp = 64'd0;
        last_vld = 1'b0;
        reset    = 1'b1;
        Stall    = 1'b0;
        PCSrc    = 3'd0;
        ALUOut0  = 1'b0;
        ConBA    = 32'd0;
        JT       = 26'd0;
        DatabusA = 32'd0;

        // reset, then sequential fetch
        add(1,0,0,0,0,0,0, 0,0,1, 1,32'h8000_0000);
        add(0,0,0,0,0,0,0, 0,1,1, 0,0);
        add(0,0,0,0,0,0,0, 0,2,1, 0,0);
        add(0,0,0,0,0,0,0, 0,3,1, 0,0);
        add(0,0,0,0,0,0,0, 0,4,1, 0,0);
        // stall fills queue, PC held once full
        add(0,1,0,0,0,0,0, 1,5,1, 0,0);
        add(0,1,0,0,0,0,0, 2,6,1, 0,0);
        add(0,1,0,0,0,0,0, 3,7,1, 0,0);
        add(0,1,0,0,0,0,0, 4,8,1, 0,0);
        add(0,1,0,0,0,0,0, 4,8,1, 0,0);
        add(0,1,0,0,0,0,0, 4,8,1, 0,0);
        // release: continuous stream from the queue
        add(0,0,0,0,0,0,0, 4,9,1, 0,0);
        add(0,0,0,0,0,0,0, 4,10,1, 0,0);
        add(0,0,0,0,0,0,0, 4,11,1, 0,0);
        // full + stall, then J overrides both
        add(0,1,0,0,0,0,0, 4,11,1, 0,0);
        add(0,1,2,0,0,26'h10,0, 0,16,1, 1,32'h8000_0040);
        add(0,0,0,0,0,0,0, 0,17,1, 0,0);
        add(0,0,0,0,0,0,0, 0,18,1, 0,0);
        // JR kernel->kernel, kernel->user, user cannot enter kernel
        add(0,0,3,0,0,0,32'h8000_0100, 0,64,1, 1,32'h8000_0100);
        add(0,0,0,0,0,0,0, 0,65,1, 0,0);
        add(0,0,3,0,0,0,32'h0000_0200, 0,0,0, 1,32'h0000_0200);
        add(0,0,0,0,0,0,0, 0,1,0, 0,0);
        add(0,0,3,0,0,0,32'h8000_0100, 0,64,0, 1,32'h0000_0100);
        add(0,0,0,0,0,0,0, 0,65,0, 0,0);
        // not-taken branch keeps the queue, taken branch flushes
        add(0,1,0,0,0,0,0, 1,66,0, 0,0);
        add(0,0,1,0,32'h20,0,0, 1,67,0, 0,0);
        add(0,0,1,1,32'h20,0,0, 0,8,0, 1,32'h0000_0020);
        add(0,0,0,0,0,0,0, 0,9,0, 0,0);
        // user PC wrap, then reset with three queued words
        add(0,0,1,1,32'h7FFF_FFFC,0,0, 0,127,0, 1,32'h7FFF_FFFC);
        add(0,1,0,0,0,0,0, 1,0,0, 0,0);
        add(0,1,0,0,0,0,0, 2,1,0, 0,0);
        add(0,1,0,0,0,0,0, 3,2,0, 0,0);
        add(1,1,0,0,0,0,0, 0,0,1, 1,32'h8000_0000);
        add(0,0,0,0,0,0,0, 0,1,1, 0,0);
        add(0,0,0,0,0,0,0, 0,2,1, 0,0);
        // vectors, then PCSrc 6/7 act as sequential
        add(0,0,4,0,0,0,0, 0,1,1, 1,32'h8000_0004);
        add(0,0,5,0,0,0,0, 0,2,1, 1,32'h8000_0008);
        add(0,0,6,0,0,0,0, 0,3,1, 0,0);
        add(0,0,7,0,0,0,0, 0,4,1, 0,0);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            Stall    = vecs[i].stall;
            PCSrc    = vecs[i].src;
            ALUOut0  = vecs[i].alu;
            ConBA    = vecs[i].conba;
            JT       = vecs[i].jt;
            DatabusA = vecs[i].dba;
            tick();
            chk($sformatf("q_count[%0d]", i),
                {61'd0, q_count}, {61'd0, vecs[i].cnt});
            chk($sformatf("imem_addr[%0d]", i),
                {57'd0, imem_addr}, {57'd0, vecs[i].addr});
            chk($sformatf("pc31[%0d]", i),
                {63'd0, PC31}, {63'd0, vecs[i].pc31});
            if (vecs[i].ld) load_stream(vecs[i].spc);
        end

        // random stall pattern: ordering and occupancy
        reset   = 1'b0;
        PCSrc   = 3'd0;
        ALUOut0 = 1'b0;
        mc      = 3'd0;
        for (int n = 0; n < 40; n++) begin
            Stall = 1'($urandom_range(0, 1));
            if (Stall && mc < 3'd4) mc = mc + 3'd1;
            tick();
            chk("rand_q_count", {61'd0, q_count}, {61'd0, mc});
        end
        Stall = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
